// File: rtl/arith_operand_loader.sv
// Operand-collecting front end for the combinational Arithmetic unit.
// Optional result chaining from DONE is enabled by defining ARITH_ACC_EN.
module arith_operand_loader #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       sw,
    input  logic [1:0]       mode_sw,
    input  logic             load_btn,
    input  logic             clear_btn,
    output logic [1:0]       alu_mode,
    output logic [7:0]       alu_i,
    input  logic [7:0]       alu_o,
    input  logic             alu_carry,
    output logic [7:0]       result,
    output logic             result_carry,
    output logic             result_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_B = 2'b01,
        EXEC   = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t             r_state;
    logic               r_load_q;
    logic [1:0]         r_alu_mode;
    logic [7:0]         r_alu_i;
    logic [7:0]         r_result;
    logic               r_result_carry;
    logic               r_result_valid;
    logic [CNT_W-1:0]   r_op_count;

    state_t             w_state_nxt;
    logic [1:0]         w_mode_nxt;
    logic [7:0]         w_i_nxt;
    logic [7:0]         w_result_nxt;
    logic               w_carry_nxt;
    logic               w_valid_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [7:0]         w_src;
    logic               w_press;

    assign w_press = load_btn & ~r_load_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_alu_mode;
        w_i_nxt      = r_alu_i;
        w_result_nxt = r_result;
        w_carry_nxt  = r_result_carry;
        w_valid_nxt  = r_result_valid;
        w_cnt_nxt    = r_op_count;
`ifdef ARITH_ACC_EN
        w_src        = (r_state == DONE) ? r_result : sw;
`else
        w_src        = sw;
`endif
        if (clear_btn) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_press) begin
                        if (r_state == DONE) w_valid_nxt = 1'b0;
                        w_mode_nxt = mode_sw;
                        if (!mode_sw[1]) begin
                            w_i_nxt     = {4'h0, w_src[3:0]};
                            w_state_nxt = WAIT_B;
                        end else begin
                            w_i_nxt     = w_src;
                            w_state_nxt = EXEC;
                        end
                    end
                end
                WAIT_B: begin
                    if (w_press) begin
                        w_i_nxt[7:4] = sw[3:0];
                        w_state_nxt  = EXEC;
                    end
                end
                EXEC: begin
                    w_result_nxt = alu_o;
                    w_carry_nxt  = alu_carry;
                    w_valid_nxt  = 1'b1;
                    w_cnt_nxt    = r_op_count + 1'b1;
                    w_state_nxt  = DONE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // load_q tracks the button even in reset so a button held across reset
    // release is not seen as a fresh press.
    always_ff @(posedge clk) begin
        r_load_q <= load_btn;
        if (!rst_n) begin
            r_state        <= IDLE;
            r_alu_mode     <= '0;
            r_alu_i        <= '0;
            r_result       <= '0;
            r_result_carry <= 1'b0;
            r_result_valid <= 1'b0;
            r_op_count     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_alu_mode     <= w_mode_nxt;
            r_alu_i        <= w_i_nxt;
            r_result       <= w_result_nxt;
            r_result_carry <= w_carry_nxt;
            r_result_valid <= w_valid_nxt;
            r_op_count     <= w_cnt_nxt;
        end
    end

    assign alu_mode     = r_alu_mode;
    assign alu_i        = r_alu_i;
    assign result       = r_result;
    assign result_carry = r_result_carry;
    assign result_valid = r_result_valid;
    assign state        = r_state;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_arith_operand_loader.sv
// Bench for arith_operand_loader: directed scenarios plus random stimulus against
// an arithmetic reference model; includes a behavioural Arithmetic unit.
module tb_arith_operand_loader;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n, clear_btn, load_btn;
    logic [7:0]       sw;
    logic [1:0]       mode_sw;
    logic [1:0]       alu_mode;
    logic [7:0]       alu_i, alu_o, result;
    logic             alu_carry, result_carry, result_valid;
    logic [1:0]       state;
    logic [CNT_W-1:0] op_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arith_operand_loader #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode_sw(mode_sw),
        .load_btn(load_btn), .clear_btn(clear_btn),
        .alu_mode(alu_mode), .alu_i(alu_i), .alu_o(alu_o), .alu_carry(alu_carry),
        .result(result), .result_carry(result_carry), .result_valid(result_valid),
        .state(state), .op_count(op_count)
    );

    // Arithmetic unit behaviour: returns {carry, o}
    function automatic logic [8:0] alu_f(input int m, input int i);
        int a, b;
        a = i % 16;
        b = i / 16;
        case (m)
            0:       return 9'(a + b);
            1:       return {(a < b) ? 1'b1 : 1'b0, 8'((a - b + 256) % 256)};
            2:       return 9'(i * 2);
            default: return {1'b0, 8'(i / 2)};
        endcase
    endfunction

    always_comb {alu_carry, alu_o} = alu_f(int'(alu_mode), int'(alu_i));

    // Reference model state
    int m_st = 0, m_mode = 0, m_i = 0, m_res = 0, m_car = 0, m_val = 0, m_cnt = 0;
    bit m_lq = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit l, input int s, input int md);
        bit press;
        int src;
        logic [8:0] ar;
        press = l && !m_lq;
        m_lq  = l;
        if (!r) begin
            m_st = 0; m_mode = 0; m_i = 0; m_res = 0; m_car = 0; m_val = 0; m_cnt = 0;
        end else if (c) begin
            m_st = 0; m_val = 0;
        end else begin
            case (m_st)
                0, 3: if (press) begin
                    src = s;
`ifdef ARITH_ACC_EN
                    if (m_st == 3) src = m_res;
`endif
                    if (m_st == 3) m_val = 0;
                    m_mode = md;
                    if (md < 2) begin m_i = src % 16; m_st = 1; end
                    else        begin m_i = src;      m_st = 2; end
                end
                1: if (press) begin
                    m_i  = (m_i % 16) + (s % 16) * 16;
                    m_st = 2;
                end
                default: begin
                    ar    = alu_f(m_mode, m_i);
                    m_res = int'(ar[7:0]);
                    m_car = int'(ar[8]);
                    m_val = 1;
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    m_st  = 3;
                end
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit l, input int s, input int md);
        @(negedge clk);
        rst_n = r; clear_btn = c; load_btn = l; sw = 8'(s); mode_sw = 2'(md);
        @(posedge clk);
        model_step(r, c, l, s, md);
        #1;
        chk("state",    32'(state),        32'(m_st));
        chk("alu_mode", 32'(alu_mode),     32'(m_mode));
        chk("alu_i",    32'(alu_i),        32'(m_i));
        chk("result",   32'(result),       32'(m_res));
        chk("carry",    32'(result_carry), 32'(m_car));
        chk("valid",    32'(result_valid), 32'(m_val));
        chk("op_count", 32'(op_count),     32'(m_cnt));
    endtask

    initial begin
        rst_n = 1'b0; clear_btn = 1'b0; load_btn = 1'b1; sw = '0; mode_sw = '0;

        cyc(0, 0, 1, 8'hA5, 2);
        cyc(0, 0, 1, 8'hA5, 2);
        chk("rst_state", 32'(state), 0);
        chk("rst_result", 32'(result), 0);
        cyc(1, 0, 1, 8'hA5, 2);
        chk("rel_nopress", 32'(state), 0);
        cyc(1, 0, 0, 0, 0);

        // add 3 + 5
        cyc(1, 0, 1, 8'h03, 0);
        cyc(1, 0, 0, 8'h03, 0);
        cyc(1, 0, 1, 8'h05, 0);
        chk("add_alu_i", 32'(alu_i), 32'h53);
        chk("add_exec", 32'(state), 2);
        cyc(1, 0, 0, 0, 0);
        chk("add_res", 32'(result), 32'h08);
        chk("add_valid", 32'(result_valid), 1);
        chk("add_cnt", 32'(op_count), 1);

        // add max F + F
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 8'h0F, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 8'h0F, 0);
        cyc(1, 0, 0, 0, 0);
        chk("add_max", 32'(result), 32'h1E);

        // shift left / right of 0x81
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 8'h81, 2);
        cyc(1, 0, 0, 0, 2);
        chk("shl_res", 32'(result), 32'h02);
        chk("shl_car", 32'(result_carry), 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 8'h81, 3);
        cyc(1, 0, 0, 0, 3);
        chk("shr_res", 32'(result), 32'h40);
        chk("shr_car", 32'(result_carry), 0);
        chk("cnt_wrap", 32'(op_count), 0);

        // press from DONE: chains from result 0x40 or uses sw=0x10
        cyc(1, 0, 1, 8'h10, 3);
        chk("done_valid_clr", 32'(result_valid), 0);
        cyc(1, 0, 0, 0, 3);
`ifdef ARITH_ACC_EN
        chk("chain_res", 32'(result), 32'h20);
`else
        chk("chain_res", 32'(result), 32'h08);
`endif

        // held button: one capture only
        cyc(1, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) cyc(1, 0, 1, (k == 0) ? 8'h07 : 8'h0C, 0);
        chk("held_state", 32'(state), 1);
        chk("held_alu_i", 32'(alu_i), 32'h07);

        // clear beats a press in WAIT_B
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 8'h09, 0);
        chk("clr_state", 32'(state), 0);
        chk("clr_valid", 32'(result_valid), 0);
        chk("clr_cnt", 32'(op_count), 1);
        chk("clr_alu_i", 32'(alu_i), 32'h07);

        // reset during EXEC
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 8'h33, 2);
        chk("pre_rst_exec", 32'(state), 2);
        cyc(0, 0, 0, 0, 0);
        chk("rst_exec_state", 32'(state), 0);
        chk("rst_exec_res", 32'(result), 0);
        chk("rst_exec_cnt", 32'(op_count), 0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            cyc(($urandom % 64) != 0, ($urandom % 24) == 0, ($urandom % 3) != 0,
                int'($urandom % 256), int'($urandom % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
